// File: rtl/char_grid_scanner_if.sv
// Signal bundle between char_grid_scanner (master), its text RAM / font ROM and the glyph renderer.
interface char_grid_scanner_if;
    logic         start;
    logic [11:0]  text_addr;
    logic [29:0]  text_data;
    logic [7:0]   font_addr;
    logic [127:0] font_data;
    logic [4:0]   cursor_row;
    logic [6:0]   cursor_col;
    logic [127:0] shape;
    logic [8:0]   fg_color;
    logic [8:0]   bg_color;
    logic [3:0]   effect;
    logic         current_cursor;
    logic [19:0]  base_address;
    logic         font_ready;
    logic         render_done;
    logic         busy;
    logic         frame_done;

    modport master (
        input  start, text_data, font_data, cursor_row, cursor_col, render_done,
        output text_addr, font_addr, shape, fg_color, bg_color, effect,
               current_cursor, base_address, font_ready, busy, frame_done
    );

    modport slave (
        output start, text_data, font_data, cursor_row, cursor_col, render_done,
        input  text_addr, font_addr, shape, fg_color, bg_color, effect,
               current_cursor, base_address, font_ready, busy, frame_done
    );
endinterface

// File: rtl/char_grid_scanner.sv
// Walks the text buffer row-major, fetches each cell and its glyph, and hands it to the renderer.
// Optional macro CURSOR_OVERLAY_EN enables the current_cursor flag; otherwise it is tied to 0.
module char_grid_scanner #(
    parameter int COLUMNS  = 80,
    parameter int ROWS     = 25,
    parameter int CHAR_W   = 8,
    parameter int CHAR_H   = 16,
    parameter int FONT_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    char_grid_scanner_if.master bus
);
    localparam int               LAT_W    = (FONT_LAT > 1) ? $clog2(FONT_LAT) : 1;
    localparam logic [4:0]       LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0]       LAST_COL = 7'(COLUMNS - 1);
    localparam logic [19:0]      COL_STEP = 20'(CHAR_W);
    localparam logic [19:0]      ROW_STEP = 20'(CHAR_H * COLUMNS * CHAR_W);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FONT_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, TEXT_REQ, TEXT_WAIT, FONT_WAIT, HOLD, ISSUE, ACK_WAIT, FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       row_q, row_d;
    logic [6:0]       col_q, col_d;
    logic [11:0]      cell_q, cell_d;
    logic [19:0]      row_base_q, row_base_d;
    logic [19:0]      col_off_q, col_off_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       font_addr_q, font_addr_d;
    logic [127:0]     shape_q, shape_d;
    logic [8:0]       fg_q, fg_d;
    logic [8:0]       bg_q, bg_d;
    logic [3:0]       effect_q, effect_d;
    logic             cursor_q, cursor_d;
    logic [19:0]      base_q, base_d;
    logic [7:0]       font_addr_c;
    logic             font_ready_c;
    logic             busy_c;
    logic             frame_done_c;
    logic             cursor_hit;
    logic             last_cell;

`ifdef CURSOR_OVERLAY_EN
    assign cursor_hit = (row_q == bus.cursor_row) && (col_q == bus.cursor_col);
`else
    assign cursor_hit = 1'b0;
`endif

    assign last_cell = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cell_q      <= '0;
            row_base_q  <= '0;
            col_off_q   <= '0;
            lat_q       <= '0;
            font_addr_q <= '0;
            shape_q     <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            effect_q    <= '0;
            cursor_q    <= 1'b0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cell_q      <= cell_d;
            row_base_q  <= row_base_d;
            col_off_q   <= col_off_d;
            lat_q       <= lat_d;
            font_addr_q <= font_addr_d;
            shape_q     <= shape_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            effect_q    <= effect_d;
            cursor_q    <= cursor_d;
            base_q      <= base_d;
        end
    end

    // font_addr is driven straight from text_data in TEXT_WAIT so the ROM latency
    // starts counting that cycle; afterwards the registered copy holds it steady.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        cell_d       = cell_q;
        row_base_d   = row_base_q;
        col_off_d    = col_off_q;
        lat_d        = lat_q;
        font_addr_d  = font_addr_q;
        shape_d      = shape_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        effect_d     = effect_q;
        cursor_d     = cursor_q;
        base_d       = base_q;
        font_addr_c  = font_addr_q;
        font_ready_c = 1'b0;
        frame_done_c = 1'b0;
        busy_c       = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    row_d      = '0;
                    col_d      = '0;
                    cell_d     = '0;
                    row_base_d = '0;
                    col_off_d  = '0;
                    state_d    = TEXT_REQ;
                end
            end
            TEXT_REQ: begin
                state_d = TEXT_WAIT;
            end
            TEXT_WAIT: begin
                fg_d        = bus.text_data[16:8];
                bg_d        = bus.text_data[25:17];
                effect_d    = bus.text_data[29:26];
                font_addr_d = bus.text_data[7:0];
                font_addr_c = bus.text_data[7:0];
                cursor_d    = cursor_hit;
                base_d      = row_base_q + col_off_q;
                lat_d       = LAT_LOAD;
                state_d     = FONT_WAIT;
            end
            FONT_WAIT: begin
                if (lat_q == '0) begin
                    shape_d = bus.font_data;
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (bus.render_done) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                font_ready_c = 1'b1;
                state_d      = ACK_WAIT;
            end
            // Waiting for render_done to fall keeps a done level left over from
            // the previous cell from being taken as acceptance of the next one.
            ACK_WAIT: begin
                if (!bus.render_done) begin
                    if (last_cell) begin
                        state_d = FINISH;
                    end else begin
                        cell_d = cell_q + 12'd1;
                        if (col_q == LAST_COL) begin
                            col_d      = '0;
                            col_off_d  = '0;
                            row_d      = row_q + 5'd1;
                            row_base_d = row_base_q + ROW_STEP;
                        end else begin
                            col_d     = col_q + 7'd1;
                            col_off_d = col_off_q + COL_STEP;
                        end
                        state_d = TEXT_REQ;
                    end
                end
            end
            FINISH: begin
                frame_done_c = 1'b1;
                busy_c       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.text_addr      = cell_q;
    assign bus.font_addr      = font_addr_c;
    assign bus.shape          = shape_q;
    assign bus.fg_color       = fg_q;
    assign bus.bg_color       = bg_q;
    assign bus.effect         = effect_q;
    assign bus.current_cursor = cursor_q;
    assign bus.base_address   = base_q;
    assign bus.font_ready     = font_ready_c;
    assign bus.busy           = busy_c;
    assign bus.frame_done     = frame_done_c;
endmodule

// File: tb/tb_char_grid_scanner.sv
// Directed bench for char_grid_scanner with text RAM, font ROM and renderer models.
// Define CURSOR_OVERLAY_EN on the build to check the cursor flag at cell (3,5).
module tb_char_grid_scanner;
    localparam int COLUMNS  = 80;
    localparam int ROWS     = 25;
    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int FONT_LAT = 2;
    localparam int NCELLS   = COLUMNS * ROWS;
    localparam int CUR_CELL = 3 * COLUMNS + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdSel = 1'b0;
    logic rdManual = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulseCount = 0;
    int   frameCount = 0;
    int   seqBad = 0;
    int   cursorHits = 0;
    int   expCell = 0;
    int   rdHoldCnt = 0;
    logic [127:0] fontPipe0 = '0;
    logic [127:0] fontPipe1 = '0;
    logic [29:0]  expWord;
    logic [19:0]  expBase;
    logic         expCursor;

    char_grid_scanner_if bus();

    char_grid_scanner #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .FONT_LAT(FONT_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] textWord(input logic [11:0] a);
        logic [7:0] ch;
        logic [8:0] fg;
        logic [8:0] bg;
        logic [3:0] eff;
        if (a == 12'd1) return {4'b0001, 9'h000, 9'h1FF, 8'h41};
        ch  = 8'(a + 12'd32);
        fg  = 9'(a * 12'd7);
        bg  = ~a[8:0];
        eff = a[3:0];
        return {eff, bg, fg, ch};
    endfunction

    function automatic logic [127:0] glyph(input logic [7:0] c);
        if (c == 8'h41) return {16{8'hA5}};
        return {8{c, ~c}};
    endfunction

    // Memory models: text RAM answers one cycle later, font ROM FONT_LAT cycles later.
    always @(posedge clk) begin
        bus.text_data <= textWord(bus.text_addr);
        fontPipe0     <= glyph(bus.font_addr);
        fontPipe1     <= fontPipe0;
    end
    assign bus.font_data = fontPipe1;

    always @(posedge clk) begin
        if (bus.font_ready) rdHoldCnt <= 3;
        else if (rdHoldCnt != 0) rdHoldCnt <= rdHoldCnt - 1;
    end
    assign bus.render_done = rdSel ? (rdHoldCnt == 0) : rdManual;

    assign expWord = textWord(12'(expCell));
    assign expBase = 20'((expCell / COLUMNS) * (CHAR_H * COLUMNS * CHAR_W) + (expCell % COLUMNS) * CHAR_W);
`ifdef CURSOR_OVERLAY_EN
    assign expCursor = (expCell == CUR_CELL);
`else
    assign expCursor = 1'b0;
`endif

    // Every handed-over cell is compared with the reference walk; mismatches are tallied.
    always @(posedge clk) begin
        if (rst) begin
            expCell <= 0;
        end else begin
            if (bus.font_ready) begin
                pulseCount <= pulseCount + 1;
                if (bus.text_addr !== 12'(expCell) || bus.base_address !== expBase ||
                    bus.fg_color !== expWord[16:8] || bus.bg_color !== expWord[25:17] ||
                    bus.effect !== expWord[29:26] || bus.shape !== glyph(expWord[7:0]) ||
                    bus.current_cursor !== expCursor)
                    seqBad <= seqBad + 1;
                if (bus.current_cursor) cursorHits <= cursorHits + 1;
                expCell <= (expCell == NCELLS - 1) ? 0 : expCell + 1;
            end
            if (bus.frame_done) frameCount <= frameCount + 1;
        end
    end

    task automatic doReset();
        rst = 1'b1;
        bus.start = 1'b0;
        rdSel = 1'b0;
        rdManual = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitFontReady(input int limit, output int cyc);
        cyc = 0;
        while (bus.font_ready !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.text_addr !== 12'd0) begin errors++; $display("[TB] FAIL reset_text_addr: got %0d expected 0", bus.text_addr); end
        checks++;
        if (bus.font_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_font_addr: got %0d expected 0", bus.font_addr); end
        checks++;
        if (bus.shape !== 128'd0) begin errors++; $display("[TB] FAIL reset_shape: got %h expected 0", bus.shape); end
        checks++;
        if ({bus.fg_color, bus.bg_color, bus.effect, bus.current_cursor} !== 23'd0) begin
            errors++; $display("[TB] FAIL reset_attrs: got %h expected 0", {bus.fg_color, bus.bg_color, bus.effect, bus.current_cursor});
        end
        checks++;
        if (bus.base_address !== 20'd0) begin errors++; $display("[TB] FAIL reset_base: got %0d expected 0", bus.base_address); end
        checks++;
        if ({bus.font_ready, bus.busy, bus.frame_done} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {bus.font_ready, bus.busy, bus.frame_done});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_first_cell();
        int cyc;
        logic [29:0] w;
        doReset();
        rdSel = 1'b0;
        rdManual = 1'b1;
        applyStimulus();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_start: got %b expected 1", bus.busy); end
        waitFontReady(20, cyc);
        checks++;
        if (cyc != 5) begin errors++; $display("[TB] FAIL first_latency: got %0d cycles expected 5", cyc); end
        w = textWord(12'd0);
        checks++;
        if (bus.text_addr !== 12'd0 || bus.base_address !== 20'd0) begin
            errors++; $display("[TB] FAIL first_addr: got text %0d base %0d expected 0 0", bus.text_addr, bus.base_address);
        end
        checks++;
        if (bus.shape !== glyph(w[7:0]) || bus.fg_color !== w[16:8] || bus.bg_color !== w[25:17]) begin
            errors++; $display("[TB] FAIL first_data: got shape %h fg %h bg %h", bus.shape, bus.fg_color, bus.bg_color);
        end
        // render_done stays high through ISSUE and the following cycle
        @(negedge clk);
        checks++;
        if (bus.font_ready !== 1'b0 || bus.text_addr !== 12'd0) begin
            errors++; $display("[TB] FAIL stale_done_1: got ready %b text %0d expected 0 0", bus.font_ready, bus.text_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.font_ready !== 1'b0 || bus.text_addr !== 12'd0) begin
            errors++; $display("[TB] FAIL stale_done_2: got ready %b text %0d expected 0 0", bus.font_ready, bus.text_addr);
        end
        rdManual = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.text_addr !== 12'd1) begin errors++; $display("[TB] FAIL no_skip: text_addr got %0d expected 1", bus.text_addr); end
    endtask

    task automatic test_cell_attributes();
        int cyc;
        rdManual = 1'b1;
        waitFontReady(20, cyc);
        checks++;
        if (cyc != 5) begin errors++; $display("[TB] FAIL cell1_latency: got %0d cycles expected 5", cyc); end
        checks++;
        if (bus.fg_color !== 9'h1FF || bus.bg_color !== 9'h000 || bus.effect !== 4'b0001) begin
            errors++; $display("[TB] FAIL cell1_colors: got fg %h bg %h eff %b expected 1ff 000 0001", bus.fg_color, bus.bg_color, bus.effect);
        end
        checks++;
        if (bus.shape !== {16{8'hA5}}) begin errors++; $display("[TB] FAIL cell1_shape: got %h expected a5..a5", bus.shape); end
        checks++;
        if (bus.base_address !== 20'd8 || bus.text_addr !== 12'd1) begin
            errors++; $display("[TB] FAIL cell1_addr: got base %0d text %0d expected 8 1", bus.base_address, bus.text_addr);
        end
    endtask

    task automatic test_hold_stall();
        int cyc;
        int bad;
        logic [29:0] w;
        w = textWord(12'd2);
        rdManual = 1'b0;
        repeat (8) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.font_ready !== 1'b0 || bus.text_addr !== 12'd2 || bus.base_address !== 20'd16 ||
                bus.shape !== glyph(w[7:0]) || bus.fg_color !== w[16:8] || bus.bg_color !== w[25:17] ||
                bus.effect !== w[29:26] || bus.busy !== 1'b1)
                bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        rdManual = 1'b1;
        waitFontReady(3, cyc);
        checks++;
        if (bus.font_ready !== 1'b1 || bus.text_addr !== 12'd2) begin
            errors++; $display("[TB] FAIL hold_release: got ready %b text %0d expected 1 2", bus.font_ready, bus.text_addr);
        end
    endtask

    task automatic test_row_wrap();
        int seen;
        int cyc;
        logic [19:0] base79;
        doReset();
        rdSel = 1'b1;
        applyStimulus();
        seen = 0;
        cyc = 0;
        base79 = '0;
        while (seen < 81 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.font_ready) begin
                seen++;
                if (seen == 80) base79 = bus.base_address;
            end
        end
        checks++;
        if (seen != 81) begin errors++; $display("[TB] FAIL wrap_reach: got %0d cells expected 81", seen); end
        checks++;
        if (base79 !== 20'd632) begin errors++; $display("[TB] FAIL wrap_last_col: base got %0d expected 632", base79); end
        checks++;
        if (bus.text_addr !== 12'd80 || bus.base_address !== 20'd10240) begin
            errors++; $display("[TB] FAIL wrap_row1: got text %0d base %0d expected 80 10240", bus.text_addr, bus.base_address);
        end
    endtask

    task automatic test_reset_midframe();
        int seen;
        int cyc;
        int framesBefore;
        doReset();
        rdSel = 1'b1;
        applyStimulus();
        seen = 0;
        cyc = 0;
        while (seen < 101 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus.font_ready) seen++;
        end
        checks++;
        if (seen != 101) begin errors++; $display("[TB] FAIL mid_reach: got %0d cells expected 101", seen); end
        framesBefore = frameCount;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.font_ready, bus.busy, bus.frame_done} !== 3'b000) begin
            errors++; $display("[TB] FAIL mid_rst_ctrl: got %b expected 000", {bus.font_ready, bus.busy, bus.frame_done});
        end
        checks++;
        if (bus.text_addr !== 12'd0 || bus.base_address !== 20'd0 || bus.shape !== 128'd0) begin
            errors++; $display("[TB] FAIL mid_rst_outputs: got text %0d base %0d expected 0 0", bus.text_addr, bus.base_address);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (frameCount != framesBefore || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_no_frame_done: got frames %0d busy %b expected %0d 0", frameCount, bus.busy, framesBefore);
        end
        applyStimulus();
        waitFontReady(20, cyc);
        checks++;
        if (cyc != 5 || bus.text_addr !== 12'd0 || bus.base_address !== 20'd0) begin
            errors++; $display("[TB] FAIL mid_restart: got cyc %0d text %0d base %0d expected 5 0 0", cyc, bus.text_addr, bus.base_address);
        end
    endtask

    task automatic test_full_frame();
        int pulses;
        int cyc;
        int busyDrops;
        int framesBefore;
        int hitsBefore;
        int extra;
        logic doneSeen;
        logic busyAtDone;
        logic [11:0] lastAddr;
        logic [19:0] lastBase;
        doReset();
        rdSel = 1'b1;
        framesBefore = frameCount;
        hitsBefore = cursorHits;
        pulses = 0;
        cyc = 0;
        busyDrops = 0;
        doneSeen = 1'b0;
        busyAtDone = 1'b1;
        lastAddr = '0;
        lastBase = '0;
        applyStimulus();
        while (!doneSeen && cyc < 40000) begin
            if (bus.start) bus.start = 1'b0;
            if (bus.frame_done) begin
                doneSeen = 1'b1;
                busyAtDone = bus.busy;
            end else begin
                if (bus.busy !== 1'b1) busyDrops++;
                if (bus.font_ready) begin
                    pulses++;
                    lastAddr = bus.text_addr;
                    lastBase = bus.base_address;
                    if (pulses == 500) bus.start = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!doneSeen) begin errors++; $display("[TB] FAIL frame_timeout: got no frame_done in %0d cycles expected one", cyc); end
        checks++;
        if (pulses != NCELLS) begin errors++; $display("[TB] FAIL frame_pulses: got %0d expected %0d", pulses, NCELLS); end
        checks++;
        if (lastAddr !== 12'd1999 || lastBase !== 20'd246392) begin
            errors++; $display("[TB] FAIL frame_last_cell: got text %0d base %0d expected 1999 246392", lastAddr, lastBase);
        end
        checks++;
        if (busyDrops != 0 || busyAtDone !== 1'b0) begin
            errors++; $display("[TB] FAIL frame_busy: got %0d drops busy_at_done %b expected 0 0", busyDrops, busyAtDone);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.font_ready || bus.busy) extra++;
        end
        checks++;
        if (frameCount - framesBefore != 1 || extra != 0) begin
            errors++; $display("[TB] FAIL frame_after: got frames %0d activity %0d expected 1 0", frameCount - framesBefore, extra);
        end
        checks++;
`ifdef CURSOR_OVERLAY_EN
        if (cursorHits - hitsBefore != 1) begin errors++; $display("[TB] FAIL cursor_hits: got %0d expected 1", cursorHits - hitsBefore); end
`else
        if (cursorHits - hitsBefore != 0) begin errors++; $display("[TB] FAIL cursor_hits: got %0d expected 0", cursorHits - hitsBefore); end
`endif
        checks++;
        if (seqBad != 0) begin errors++; $display("[TB] FAIL cell_sequence: got %0d bad cells expected 0", seqBad); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cursor_row = 5'd3;
        bus.cursor_col = 7'd5;
        test_reset();
        test_first_cell();
        test_cell_attributes();
        test_hold_stall();
        test_row_wrap();
        test_reset_midframe();
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/char_grid_scanner.md
Name: char_grid_scanner

Overview:
- Upstream feeder of the per-character font shape renderer.
- Walks the console text buffer cell by cell in row-major order.
- For each cell it reads the text cell and then that character's font bitmap, and computes the cell's framebuffer base address.
- It presents the assembled cell to the renderer through a font_ready/render_done handshake, one cell at a time, and pulses frame_done after the last cell.

Parameters:
COLUMNS, 80, console columns
ROWS, 25, console rows
CHAR_W, 8, pixels per character horizontally
CHAR_H, 16, pixels per character vertically
FONT_LAT, 2, font ROM read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a frame scan; sampled only in IDLE
text_addr  out  12  text RAM cell index, row*COLUMNS+col
text_data  in  30  cell read data, valid exactly 1 cycle after text_addr; [7:0] char code, [16:8] fg colour, [25:17] bg colour, [29:26] effect {negative,blink,underline,bright}
font_addr  out  8  font ROM character index
font_data  in  128  glyph bitmap, valid FONT_LAT cycles after font_addr; bit 127 = top-left pixel
cursor_row  in  5  cursor row
cursor_col  in  7  cursor column
shape  out  128  glyph bitmap of the presented cell
fg_color  out  9  foreground colour
bg_color  out  9  background colour
effect  out  4  effect bits, same order as text_data
current_cursor  out  1  presented cell is the cursor cell
base_address  out  20  framebuffer address of the cell's top-left pixel
font_ready  out  1  one-cycle pulse: cell outputs valid, renderer may load them
render_done  in  1  renderer idle and able to accept a cell (level)
busy  out  1  high from start acceptance until frame_done
frame_done  out  1  one-cycle pulse after the last cell is handed over

Behaviour:
- Reset values: all outputs 0; state IDLE; row/col counters 0.
- States: IDLE, TEXT_REQ, TEXT_WAIT, FONT_WAIT, HOLD, ISSUE, ACK_WAIT, FINISH.
- IDLE: on start=1, clear row/col and row_base, set busy, go to TEXT_REQ. start is ignored in all other states.
- TEXT_REQ: drive text_addr; go to TEXT_WAIT.
- TEXT_WAIT:
  - Capture text_data into fg_color, bg_color and effect.
  - Drive font_addr = char code.
  - Load the latency counter with FONT_LAT-1; go to FONT_WAIT.
- FONT_WAIT:
  - Count down; at 0, capture font_data into shape and go to HOLD.
  - Timing: shape is captured exactly FONT_LAT cycles after font_addr was first driven.
- HOLD: wait until render_done=1, then go to ISSUE.
- ISSUE: font_ready=1 for this cycle only; go to ACK_WAIT.
- Output stability: shape, fg_color, bg_color, effect, current_cursor and base_address are stable from HOLD entry through the ISSUE cycle and the cycle after it.
- ACK_WAIT: wait until render_done=0, so a stale done is never counted twice, then advance the counters.
  - Last cell (row=ROWS-1, col=COLUMNS-1) → FINISH.
  - Otherwise → TEXT_REQ.
- FINISH: frame_done=1 for one cycle, busy=0, go to IDLE.
- Address arithmetic, incremental with no multiplier on the cell path:
  - base_address = row_base + col*CHAR_W.
  - Column advance adds CHAR_W.
  - Row wrap: col←0 and row_base += CHAR_H*COLUMNS*CHAR_W.
  - text_addr increments by 1 per cell.
  - Last cell with defaults: text_addr=1999, base_address=24*10240+79*8=246392.
- Per-cell latency from TEXT_REQ to HOLD is 2+FONT_LAT cycles.
- Throughput is bounded by render_done.
- rst mid-frame: immediate return to IDLE; font_ready, frame_done and busy drop to 0; no frame_done pulse is emitted.

Optional Feature:
- Macro CURSOR_OVERLAY_EN.
- Defined: current_cursor = (row==cursor_row && col==cursor_col), registered together with the other cell outputs in TEXT_WAIT.
- Undefined: current_cursor is constant 0, and the cursor_row/cursor_col inputs are unused.

Test Plan:
- Reset, then start=1 with render_done held 1 → first font_ready 5 cycles after start (FONT_LAT=2); text_addr=0, base_address=0.
- Cell (0,1) with text_data={4'b0001,9'h000,9'h1FF,8'h41} and font_data=128'hA5…A5 → fg_color=9'h1FF, bg_color=0, effect=4'b0001, shape matches, base_address=8.
- Cell (1,0) → text_addr=80, base_address=10240.
- render_done held 1 through the ISSUE cycle and the next cycle → exactly one font_ready pulse, no skipped cell; render_done held 0 for 20 cycles in HOLD → outputs stable, font_ready stays 0.
- Full frame with render_done auto-acked → exactly 2000 font_ready pulses, then one frame_done; busy=0 afterwards; start during the frame has no effect.
- With CURSOR_OVERLAY_EN and cursor (3,5) → current_cursor=1 only for text_addr=245; rst asserted at cell 100 → IDLE, outputs 0, and a new start restarts at text_addr=0.
